debug_scan_sequencer: RTL and testbench

Sequences the tag's debug observation mux in the debug_clk domain.
- Synchronises up to 16 internal status probes (packet_complete, cmd_complete, handlematch, docrc, rx_en, tx_en, txsetupdone, ...).
- Picks which probe to report: round-robin over enabled probes, or a fixed address.
- Serialises each report as a framed, parity-protected bit stream on one debug pin.
- Sticky capture ensures single-cycle (post-sync) events are not lost between reports.

---
 rtl/debug_scan_sequencer.sv | 168 ++++++++++++++++
 tb/tb_debug_scan_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_scan_sequencer.sv
// Purpose: picks one synchronised debug probe per frame (round-robin or fixed) and shifts it out on one pin.
// Latency: enable sampled in IDLE at edge k -> LOAD after k, start bit visible after k+1; frame period 1 + 9 + GAP cycles.
// Backpressure: none; enable only gates the start of a frame, a frame in flight always runs through its stop bit.
//
// Ports:
//   debug_clk    - debug clock, all state on its rising edge
//   reset        - asynchronous, active-high; aborts any frame and zeroes all state
//   enable       - allows new frames to start (synchronous to debug_clk)
//   scan_mode    - 1: round-robin over probe_mask, 0: report fixed_addr only
//   fixed_addr   - probe reported when scan_mode = 0
//   probe_mask   - bit i = 1 makes probe i selectable
//   probe_in     - raw asynchronous probe levels
//   debug_out    - serial frame: start, addr[3:0], lvl, stk, even parity, stop; 0 when idle
//   frame_active - high for the 9 serial bit cycles only
//   cur_addr     - address of the frame in flight or last sent
//   frame_count  - completed frames, wraps 255 -> 0
module debug_scan_sequencer #(
    parameter int NPROBE      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int GAP         = 2
) (
    input  logic              debug_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              scan_mode,
    input  logic [3:0]        fixed_addr,
    input  logic [NPROBE-1:0] probe_mask,
    input  logic [NPROBE-1:0] probe_in,
    output logic              debug_out,
    output logic              frame_active,
    output logic [3:0]        cur_addr,
    output logic [7:0]        frame_count
);

    // Fewer than two stages would not be a synchroniser; clamp rather than build one.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t            state;
    logic [NPROBE-1:0] sync_q [SS];
    logic [NPROBE-1:0] syncd;
    logic [NPROBE-1:0] sticky;
    logic [NPROBE-1:0] load_clr;
    logic [3:0]        ptr;
    logic [3:0]        bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [7:0]        shreg;
    logic [3:0]        rr_addr;
    logic [3:0]        sel_addr;
    logic              sel_lvl;
    logic              sel_stk;
    logic              selectable;
    logic              start_ok;

    // First mask bit at or above 'from', wrapping 15 -> 0. Returns 'from' when
    // nothing is set; that case cannot reach LOAD through the IDLE rule.
    function automatic logic [3:0] rr_pick(input logic [NPROBE-1:0] mask,
                                           input logic [3:0]        from);
        logic [3:0] idx;
        logic       found;
        rr_pick = from;
        found   = 1'b0;
        for (int k = 0; k < NPROBE; k++) begin
            idx = from + 4'(k);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign syncd      = sync_q[SS-1];
    assign rr_addr    = rr_pick(probe_mask, ptr);
    assign sel_addr   = scan_mode ? rr_addr : fixed_addr;
    assign sel_lvl    = syncd[sel_addr];
    assign sel_stk    = sticky[sel_addr] | syncd[sel_addr];
    assign selectable = scan_mode ? (|probe_mask) : probe_mask[fixed_addr];
    assign start_ok   = enable & selectable;

    always_comb begin
        load_clr = '0;
        if (state == S_LOAD) begin
            load_clr[sel_addr] = 1'b1;
        end
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SS; s++) begin
                sync_q[s] <= '0;
            end
            sticky <= '0;
        end else begin
            sync_q[0] <= probe_in;
            for (int s = 1; s < SS; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            // Set wins over the LOAD-cycle clear so a coincident event is kept.
            sticky <= (sticky & ~load_clr) | syncd;
        end
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            debug_out    <= 1'b0;
            frame_active <= 1'b0;
            cur_addr     <= 4'd0;
            frame_count  <= 8'd0;
            ptr          <= 4'd0;
            bit_cnt      <= 4'd0;
            gap_cnt      <= '0;
            shreg        <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state        <= S_SHIFT;
                    cur_addr     <= sel_addr;
                    if (scan_mode) begin
                        ptr <= sel_addr + 4'd1;
                    end
                    // Start bit goes out now; the rest of the frame waits in shreg, msb first.
                    debug_out    <= 1'b1;
                    frame_active <= 1'b1;
                    bit_cnt      <= 4'd0;
                    shreg        <= {sel_addr, sel_lvl, sel_stk,
                                     ^{sel_addr, sel_lvl, sel_stk}, 1'b0};
                end
                S_SHIFT: begin
                    if (bit_cnt == 4'd8) begin
                        debug_out    <= 1'b0;
                        frame_active <= 1'b0;
                        frame_count  <= frame_count + 8'd1;
                        gap_cnt      <= '0;
                        if (GAP > 0) begin
                            state <= S_GAP;
                        end else if (start_ok) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        debug_out <= shreg[7];
                        shreg     <= {shreg[6:0], 1'b0};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= start_ok ? S_LOAD : S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scan_sequencer.sv
// Bench for debug_scan_sequencer: directed stimulus pushes expected frames into a queue,
// an independent monitor deserialises every frame on debug_out and compares against it.
// A second instance built with GAP = 0 covers the back-to-back frame period.
module tb_debug_scan_sequencer;

    logic        debug_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        scan_mode;
    logic [3:0]  fixed_addr;
    logic [15:0] probe_mask;
    logic [15:0] probe_in;
    logic        debug_out;
    logic        frame_active;
    logic [3:0]  cur_addr;
    logic [7:0]  frame_count;

    logic        enable0;
    logic        debug_out0;
    logic        frame_active0;
    logic [3:0]  cur_addr0;
    logic [7:0]  frame_count0;

    always #5 debug_clk = ~debug_clk;

    debug_scan_sequencer #(.NPROBE(16), .SYNC_STAGES(2), .GAP(2)) dut (
        .debug_clk    (debug_clk),
        .reset        (reset),
        .enable       (enable),
        .scan_mode    (scan_mode),
        .fixed_addr   (fixed_addr),
        .probe_mask   (probe_mask),
        .probe_in     (probe_in),
        .debug_out    (debug_out),
        .frame_active (frame_active),
        .cur_addr     (cur_addr),
        .frame_count  (frame_count)
    );

    debug_scan_sequencer #(.NPROBE(16), .SYNC_STAGES(2), .GAP(0)) dut0 (
        .debug_clk    (debug_clk),
        .reset        (reset),
        .enable       (enable0),
        .scan_mode    (1'b0),
        .fixed_addr   (4'd0),
        .probe_mask   (16'h0001),
        .probe_in     (16'h0000),
        .debug_out    (debug_out0),
        .frame_active (frame_active0),
        .cur_addr     (cur_addr0),
        .frame_count  (frame_count0)
    );

    typedef struct packed {
        logic [3:0] addr;
        logic       lvl;
        logic       stk;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned start_q[$];
    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          mon_frames = 0;

    always @(posedge debug_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic push(input logic [3:0] a, input logic l, input logic s);
        exp_q.push_back({a, l, s});
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (mon_frames < target && n < budget) begin
            @(negedge debug_clk);
            n++;
        end
        check(name, mon_frames, target);
    endtask

    task automatic wait_fa(input logic val, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge debug_clk);
            n++;
        end while (frame_active !== val && n < budget);
        check(name, frame_active, val);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        @(negedge debug_clk);
        reset = 1'b1;
        repeat (2) @(negedge debug_clk);
        mon_frames = 0;
        reset = 1'b0;
    endtask

    // Monitor: deserialises each frame of the GAP=2 instance and checks it against the queue.
    initial begin : monitor
        logic [8:0] got;
        logic [8:0] want;
        logic [3:0] addr_seen;
        logic       aborted;
        int         fa_len;
        exp_t       e;
        forever begin
            @(negedge debug_clk);
            if (!reset && frame_active === 1'b1) begin
                start_q.push_back(cyc);
                got       = '0;
                got[8]    = debug_out;
                addr_seen = cur_addr;
                aborted   = 1'b0;
                fa_len    = 1;
                for (int i = 7; i >= 0; i--) begin
                    @(negedge debug_clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[i] = debug_out;
                    if (frame_active === 1'b1) fa_len++;
                end
                if (!aborted) begin
                    @(negedge debug_clk);
                    if (reset) aborted = 1'b1;
                end
                if (aborted) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    check("frame_active width", fa_len + ((frame_active === 1'b1) ? 1 : 0), 9);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected frame: addr %0d bits 0x%0h, expected no frame", addr_seen, got);
                    end else begin
                        e    = exp_q.pop_front();
                        want = {1'b1, e.addr, e.lvl, e.stk, ^{e.addr, e.lvl, e.stk}, 1'b0};
                        check("frame bits", got, want);
                        check("frame cur_addr", addr_seen, e.addr);
                    end
                    mon_frames++;
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin : stim
        int          active_cycles;
        logic        prev;
        int unsigned rises[$];

        reset = 1'b1; enable = 1'b0; enable0 = 1'b0;
        scan_mode = 1'b0; fixed_addr = 4'd0; probe_mask = 16'h0; probe_in = 16'h0;
        repeat (3) @(negedge debug_clk);
        check("reset debug_out", debug_out, 0);
        check("reset frame_active", frame_active, 0);
        check("reset cur_addr", cur_addr, 0);
        check("reset frame_count", frame_count, 0);
        reset = 1'b0;
        @(negedge debug_clk);

        // 1: fixed address 11, probe held high -> 1,1,0,1,1,1,1,1,0
        probe_in[11] = 1'b1; scan_mode = 1'b0; fixed_addr = 4'd11; probe_mask = 16'h0800;
        repeat (3) @(negedge debug_clk);
        push(4'd11, 1'b1, 1'b1);
        enable = 1'b1;
        @(negedge debug_clk);
        check("LOAD frame_active", frame_active, 0);
        check("LOAD debug_out", debug_out, 0);
        enable = 1'b0;
        @(negedge debug_clk);
        check("start frame_active", frame_active, 1);
        check("start bit", debug_out, 1);
        wait_frames(1, 40, "t1 frames");
        check("t1 cur_addr", cur_addr, 11);
        check("t1 frame_count", frame_count, 1);
        probe_in = 16'h0;

        // 2: round-robin over probes 0 and 2, 12-cycle period
        do_reset();
        start_q.delete();
        scan_mode = 1'b1; probe_mask = 16'h0005;
        push(4'd0, 1'b0, 1'b0); push(4'd2, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b0); push(4'd2, 1'b0, 1'b0);
        enable = 1'b1;
        wait_frames(4, 100, "t2 frames");
        enable = 1'b0;
        check("t2 frame_count", frame_count, 4);
        check("t2 start count", start_q.size(), 4);
        if (start_q.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("t2 frame period", start_q[i] - start_q[i-1], 12);
        end

        // 3: one-cycle pulse on probe 3 is held by sticky for exactly one report
        do_reset();
        scan_mode = 1'b1; probe_mask = 16'hFFFF;
        probe_in[3] = 1'b1;
        @(negedge debug_clk);
        probe_in[3] = 1'b0;
        repeat (3) @(negedge debug_clk);
        for (int i = 0; i < 20; i++) push(4'(i % 16), 1'b0, (i == 3));
        enable = 1'b1;
        wait_frames(20, 300, "t3 frames");
        enable = 1'b0;
        check("t3 frame_count", frame_count, 20);

        // 4: nothing selectable -> stays idle
        do_reset();
        scan_mode = 1'b1; probe_mask = 16'h0000; enable = 1'b1;
        active_cycles = 0;
        repeat (30) begin
            @(negedge debug_clk);
            if (frame_active !== 1'b0 || debug_out !== 1'b0) active_cycles++;
        end
        check("t4 empty mask activity", active_cycles, 0);
        check("t4 empty mask frame_count", frame_count, 0);
        scan_mode = 1'b0; fixed_addr = 4'd5; probe_mask = 16'hFFDF;
        active_cycles = 0;
        repeat (30) begin
            @(negedge debug_clk);
            if (frame_active !== 1'b0 || debug_out !== 1'b0) active_cycles++;
        end
        check("t4 masked fixed activity", active_cycles, 0);
        check("t4 masked fixed frame_count", frame_count, 0);
        enable = 1'b0;

        // 5a: enable drops at bit 3 -> frame completes, then idle
        do_reset();
        scan_mode = 1'b0; fixed_addr = 4'd2; probe_mask = 16'h0004;
        push(4'd2, 1'b0, 1'b0);
        enable = 1'b1;
        wait_fa(1'b1, 10, "t5a frame start");
        repeat (3) @(negedge debug_clk);
        enable = 1'b0;
        wait_frames(1, 30, "t5a frames");
        repeat (20) @(negedge debug_clk);
        check("t5a frame_count", frame_count, 1);
        check("t5a frames seen", mon_frames, 1);
        check("t5a idle frame_active", frame_active, 0);

        // 5b: reset at bit 5 of the second frame, then restart from pointer 0
        do_reset();
        scan_mode = 1'b1; probe_mask = 16'h0003; probe_in[1] = 1'b1;
        repeat (3) @(negedge debug_clk);
        push(4'd0, 1'b0, 1'b0); push(4'd1, 1'b1, 1'b1); push(4'd0, 1'b0, 1'b0);
        enable = 1'b1;
        wait_fa(1'b1, 10, "t5b first start");
        wait_fa(1'b0, 20, "t5b first end");
        wait_fa(1'b1, 10, "t5b second start");
        repeat (5) @(negedge debug_clk);
        check("t5b bit5 lvl before reset", debug_out, 1);
        #2 reset = 1'b1;
        #1;
        check("t5b reset debug_out", debug_out, 0);
        check("t5b reset frame_active", frame_active, 0);
        check("t5b reset cur_addr", cur_addr, 0);
        check("t5b reset frame_count", frame_count, 0);
        repeat (2) @(negedge debug_clk);
        reset = 1'b0;
        wait_frames(2, 40, "t5b frames after reset");
        enable = 1'b0;
        check("t5b frame_count", frame_count, 1);
        probe_in = 16'h0;

        // 6a: 256 frames -> frame_count wraps to 0
        do_reset();
        scan_mode = 1'b0; fixed_addr = 4'd0; probe_mask = 16'h0001;
        for (int i = 0; i < 256; i++) push(4'd0, 1'b0, 1'b0);
        enable = 1'b1;
        wait_frames(255, 255 * 12 + 50, "t6 255 frames");
        check("t6 frame_count 255", frame_count, 255);
        wait_frames(256, 50, "t6 256 frames");
        enable = 1'b0;
        check("t6 frame_count wrap", frame_count, 0);

        // 6b: GAP = 0 instance runs back to back every 10 cycles
        do_reset();
        enable0 = 1'b1;
        prev = frame_active0;
        for (int n = 0; n < 200 && rises.size() < 4; n++) begin
            @(negedge debug_clk);
            if (frame_active0 === 1'b1 && prev === 1'b0) rises.push_back(cyc);
            prev = frame_active0;
        end
        enable0 = 1'b0;
        check("t6 gap0 starts", rises.size(), 4);
        if (rises.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("t6 gap0 period", rises[i] - rises[i-1], 10);
        end

        repeat (20) @(negedge debug_clk);
        check("expected frames drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
